// File: rtl/counter_sequencer.sv
// Run/hold/clear sequencer for a decade counter: prescaled enable, terminal detect, dwell.
// Define COUNTER_SEQUENCER_WRAPCNT_EN to add the saturating 8-bit wraps output.
module counter_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TOP     = 9,
  parameter int HOLD    = 3,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   count,
  output logic               cnt_en,
  output logic               cnt_rst,
  output logic               busy,
  output logic [1:0]         state,
  output logic               wrap
`ifdef COUNTER_SEQUENCER_WRAPCNT_EN
  ,
  output logic [7:0]         wraps
`endif
);

  localparam int DW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW-1:0] DWELL_INIT = DW'(HOLD - 1);
  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_HOLD  = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

  state_t             r_state;
  logic [PRESC_W-1:0] r_pre;
  logic [DW-1:0]      r_dwell;
  logic               r_stop_pend;

  logic w_terminal;
  logic w_pre_hit;
  logic w_start_ok;
  logic w_in_run;
  logic w_in_clear;

  // Anything at or beyond TOP counts as terminal.
  assign w_terminal = (count >= TOP_V);
  assign w_pre_hit  = (r_pre >= presc);
  assign w_start_ok = start & ~stop;
  assign w_in_run   = (r_state == S_RUN);
  assign w_in_clear = (r_state == S_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_dwell     <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state <= S_RUN;
            r_pre   <= '0;
          end
        end
        S_RUN: begin
          r_pre <= w_pre_hit ? '0 : r_pre + 1'b1;
          if (stop) begin
            r_state     <= S_CLEAR;
            r_stop_pend <= 1'b1;
          end else if (w_terminal) begin
            r_state <= S_HOLD;
            r_dwell <= DWELL_INIT;
          end
        end
        S_HOLD: begin
          if (stop) begin
            r_state     <= S_CLEAR;
            r_stop_pend <= 1'b1;
          end else if (r_dwell == '0) begin
            r_state <= S_CLEAR;
          end else begin
            r_dwell <= r_dwell - 1'b1;
          end
        end
        S_CLEAR: begin
          r_stop_pend <= 1'b0;
          if (r_stop_pend | stop) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RUN;
            r_pre   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign state   = r_state;
  assign busy    = (r_state != S_IDLE);
  assign cnt_rst = w_in_clear;
  assign wrap    = w_in_clear & ~r_stop_pend;
  assign cnt_en  = w_in_run & w_pre_hit & ~w_terminal & ~stop;

`ifdef COUNTER_SEQUENCER_WRAPCNT_EN
  logic [7:0] r_wraps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wraps <= '0;
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_wraps <= '0;
    end else if (wrap && (r_wraps != 8'hFF)) begin
      r_wraps <= r_wraps + 8'd1;
    end
  end

  assign wraps = r_wraps;
`endif

endmodule
